// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Operation sequencer for the calculator integer datapath. Accepts
//            one request at a time over op_valid/op_ready, latches operands,
//            runs single-cycle ALU ops directly and multiply/divide on
//            iterative shift-add / restoring-divide engines. Owns the "last
//            result" register consumed by the shift/rotate ops.
// Config   : ALU_SEQ_DIV_EN - when defined, the divider engine and DIV state
//            are built and opcode 0011 divides; otherwise 0011 reports err.
// Ports    : clk      - system clock, rising edge
//            rst      - asynchronous active-high reset
//            op_valid - request present
//            op_ready - request accepted when high (IDLE only)
//            op_code  - 4-bit operation select
//            op_a     - operand A (WIDTH)
//            op_b     - operand B (WIDTH)
//            busy     - high outside IDLE
//            done     - one-cycle pulse when result/flags/err update
//            result   - last completed result (2*WIDTH)
//            flags    - {zero, neg, carry, ovf} of last result
//            err      - last op unsupported or divide-by-zero
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [3:0]         op_code,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [3:0]         flags,
    output logic               err
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_EXEC = 3'd1;
    localparam logic [2:0] c_S_MUL  = 3'd2;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [2:0] c_S_DIV  = 3'd3;
`endif
    localparam logic [2:0] c_S_DONE = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    // Shared engine registers: multiply {hi=partial product, lo=multiplier};
    // divide {hi=remainder, lo=dividend shifting out / quotient shifting in}.
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_iter_last;
    logic [WIDTH-1:0]   w_low;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_exec_res;
    logic               w_exec_carry;
    logic               w_exec_ovf;
    logic               w_exec_err;

    assign op_ready    = (r_state == c_S_IDLE);
    assign busy        = (r_state != c_S_IDLE);
    assign done        = (r_state == c_S_DONE);
    assign w_accept    = op_valid && op_ready;
    assign w_iter_last = (r_cnt == c_CNT_W'(WIDTH));

    // result does not change between accept and DONE, so reading it in EXEC
    // yields the previous op's result as held at the accepting edge.
    assign w_low  = result[WIDTH-1:0];
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // One shift-add step: add B when the current multiplier LSB is set, then
    // shift the {carry, hi, lo} triple right by one.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0] w_div_shift;
    logic [WIDTH:0] w_div_trial;
    logic           w_div_ge;

    // Restoring step: remainder < B so the shifted value fits WIDTH+1 bits;
    // the trial subtraction sign bit tells whether it went negative.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_b};
    assign w_div_ge    = ~w_div_trial[WIDTH];
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    if (op_code == 4'b0010) begin
                        w_next = c_S_MUL;
`ifdef ALU_SEQ_DIV_EN
                    end else if ((op_code == 4'b0011) && (op_b != '0)) begin
                        w_next = c_S_DIV;
`endif
                    end else begin
                        // Divide-by-zero and unsupported codes also go here.
                        w_next = c_S_EXEC;
                    end
                end
            end
            c_S_EXEC: w_next = c_S_DONE;
            c_S_MUL:  if (w_iter_last) w_next = c_S_DONE;
`ifdef ALU_SEQ_DIV_EN
            c_S_DIV:  if (w_iter_last) w_next = c_S_DONE;
`endif
            c_S_DONE: w_next = c_S_IDLE;
            default:  w_next = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle operation decode
    // ------------------------------------------------------------------
    always_comb begin
        w_exec_res   = '0;
        w_exec_carry = 1'b0;
        w_exec_ovf   = 1'b0;
        w_exec_err   = 1'b0;
        case (r_op)
            4'b0000: begin
                w_exec_res   = w_sum[WIDTH-1:0];
                w_exec_carry = w_sum[WIDTH];
                w_exec_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                               (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            4'b0001: begin
                w_exec_res   = w_diff[WIDTH-1:0];
                w_exec_carry = ~w_diff[WIDTH];  // no-borrow
                w_exec_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                               (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            4'b1000: w_exec_res = r_a & r_b;
            4'b1001: w_exec_res = r_a | r_b;
            4'b1010: w_exec_res = ~(r_a | r_b);
            4'b1011: w_exec_res = ~r_a;
            4'b1100: w_exec_res = {w_low[WIDTH-2:0], 1'b0};
            4'b1101: w_exec_res = {1'b0, w_low[WIDTH-1:1]};
            4'b1110: w_exec_res = {w_low[WIDTH-1], w_low[WIDTH-1:1]};
            4'b1111: w_exec_res = {w_low[0], w_low[WIDTH-1:1]};
            // 0011 arrives here only as divide-by-zero (or with no divider);
            // 01xx is the unsupported float slot.
            default: w_exec_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, engines and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_cnt  <= '0;
            result <= '0;
            flags  <= '0;
            err    <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op_code;
                        r_a   <= op_a;
                        r_b   <= op_b;
                        r_hi  <= '0;
                        r_lo  <= op_a;
                        r_cnt <= '0;
                    end
                end
                c_S_EXEC: begin
                    result <= {{WIDTH{1'b0}}, w_exec_res};
                    flags  <= {(w_exec_res == '0), w_exec_res[WIDTH-1],
                               w_exec_carry, w_exec_ovf};
                    err    <= w_exec_err;
                end
                c_S_MUL: begin
                    if (w_iter_last) begin
                        result <= {r_hi, r_lo};
                        flags  <= {({r_hi, r_lo} == '0), r_hi[WIDTH-1], 2'b00};
                        err    <= 1'b0;
                    end else begin
                        r_hi  <= w_mul_sum[WIDTH:1];
                        r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                c_S_DIV: begin
                    if (w_iter_last) begin
                        result <= {r_hi, r_lo};
                        flags  <= {({r_hi, r_lo} == '0), 3'b000};
                        err    <= 1'b0;
                    end else begin
                        if (w_div_ge) begin
                            r_hi <= w_div_trial[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hi <= w_div_shift[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer. Stimulus pushes expected
//            {result, flags, err, done cycle} into a queue; a monitor pops and
//            compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int WIDTH = 32;
    localparam int c_MUL_LAT = WIDTH + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               op_valid = 1'b0;
    logic               op_ready;
    logic [3:0]         op_code = '0;
    logic [WIDTH-1:0]   op_a = '0;
    logic [WIDTH-1:0]   op_b = '0;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic [3:0]         flags;
    logic               err;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  flg;
        logic        e;
        int          due;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flags    (flags),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                exp_t e;
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_consecutive at cycle %0d", cyc);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cycle %0d result %h", cyc, result);
                end else begin
                    e = exp_q.pop_front();
                    if (result !== e.res || flags !== e.flg || err !== e.e || cyc != e.due) begin
                        errors++;
                        $display("FAIL op%0d got res=%h flags=%b err=%b cyc=%0d expected res=%h flags=%b err=%b cyc=%0d",
                                 e.tag, result, flags, err, cyc, e.res, e.flg, e.e, e.due);
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    // Issue one request; lat < 0 means no result is expected (aborted op).
    task automatic issue(input int tag, input logic [3:0] oc, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] er,
                         input logic [3:0] ef, input logic ee, input int lat);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout op%0d op_ready %b expected 1", tag, op_ready);
        end else begin
            op_valid = 1'b1;
            op_code  = oc;
            op_a     = a;
            op_b     = b;
            @(posedge clk);
            #1;
            if (lat >= 0) begin
                e.res = er;
                e.flg = ef;
                e.e   = ee;
                e.due = cyc + lat;
                e.tag = tag;
                exp_q.push_back(e);
            end
            op_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        int   n;
        int   bad;
        exp_t e;

        // Reset state
        #2;
        check("rst_op_ready", {63'd0, op_ready}, 64'd1);
        check("rst_busy",     {63'd0, busy},     64'd0);
        check("rst_done",     {63'd0, done},     64'd0);
        check("rst_result",   result,            64'd0);
        check("rst_flags",    {60'd0, flags},    64'd0);
        check("rst_err",      {63'd0, err},      64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Make result nonzero, then abort a multiply with reset at iteration 10
        issue(1, 4'b0000, 32'd3, 32'd4, 64'd7, 4'b0000, 1'b0, 1);
        drain();
        issue(2, 4'b0010, 32'd5, 32'd7, 64'd0, 4'b0000, 1'b0, -1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_op_ready", {63'd0, op_ready}, 64'd1);
        check("abort_busy",     {63'd0, busy},     64'd0);
        check("abort_result",   result,            64'd0);
        check("abort_flags",    {60'd0, flags},    64'd0);
        check("abort_err",      {63'd0, err},      64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);  // any stray done is flagged by the monitor

        // Add/sub boundaries
        issue(3, 4'b0000, 32'hFFFFFFFF, 32'h00000001, 64'd0, 4'b1010, 1'b0, 1);
        issue(4, 4'b0001, 32'h80000000, 32'h00000001, 64'h7FFFFFFF, 4'b0011, 1'b0, 1);

        // Multiply full width
        issue(5, 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 4'b0100, 1'b0, c_MUL_LAT);

        // Divide
`ifdef ALU_SEQ_DIV_EN
        issue(6, 4'b0011, 32'd100, 32'd7, {32'd2, 32'd14}, 4'b0000, 1'b0, c_MUL_LAT);
`else
        issue(6, 4'b0011, 32'd100, 32'd7, 64'd0, 4'b1000, 1'b1, 1);
`endif
        issue(7, 4'b0011, 32'd5, 32'd0, 64'd0, 4'b1000, 1'b1, 1);

        // Shift chain on the last result
        issue(8,  4'b0000, 32'h80000001, 32'd0, 64'h80000001, 4'b0100, 1'b0, 1);
        issue(9,  4'b1111, 32'd0, 32'd0, 64'hC0000000, 4'b0100, 1'b0, 1);
        issue(10, 4'b1110, 32'd0, 32'd0, 64'hE0000000, 4'b0100, 1'b0, 1);
        issue(11, 4'b1101, 32'd0, 32'd0, 64'h70000000, 4'b0000, 1'b0, 1);
        issue(12, 4'b1100, 32'd0, 32'd0, 64'hE0000000, 4'b0100, 1'b0, 1);

        // Logic ops
        issue(13, 4'b1000, 32'hF0F0F0F0, 32'h0FF00FF0, 64'h00F000F0, 4'b0000, 1'b0, 1);
        issue(14, 4'b1001, 32'hF0000000, 32'h0000000F, 64'hF000000F, 4'b0100, 1'b0, 1);
        issue(15, 4'b1010, 32'hFFFF0000, 32'h0000FFFF, 64'd0, 4'b1000, 1'b0, 1);
        issue(16, 4'b1011, 32'h00000000, 32'h12345678, 64'hFFFFFFFF, 4'b0100, 1'b0, 1);

        // Unsupported float slot
        issue(17, 4'b0101, 32'd9, 32'd9, 64'd0, 4'b1000, 1'b1, 1);
        drain();

        // op_valid held with changing inputs during a multiply
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 4'b0010;
        op_a     = 32'd3;
        op_b     = 32'd9;
        @(posedge clk);
        #1;
        e.res = 64'd27;
        e.flg = 4'b0000;
        e.e   = 1'b0;
        e.due = cyc + c_MUL_LAT;
        e.tag = 18;
        exp_q.push_back(e);
        n   = 0;
        bad = 0;
        while (n < 100) begin
            @(negedge clk);
            if (done) begin
                op_valid = 1'b0;
                break;
            end
            if (op_ready) bad++;
            op_code = n[3:0];
            op_a    = $urandom;
            op_b    = $urandom;
            n++;
        end
        op_valid = 1'b0;
        check("held_valid_ready_low", 64'(bad), 64'd0);
        check("held_valid_finished", {63'd0, (n < 100)}, 64'd1);
        repeat (5) @(negedge clk);
        check("held_valid_no_extra", 64'(exp_q.size()), 64'd0);
        check("idle_after_ops", {63'd0, op_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Operation sequencer for the calculator's integer datapath. Accepts one operation request at a time over a valid/ready handshake and latches the operands. Single-cycle ops (add/sub/logic/shift) complete in one cycle; multiply and divide run on iterative shift-add and restoring-divide engines. Sits between the debounced button/operand-entry logic and the display result register, and owns the "last result" register that the shift ops consume.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH; multiply/divide take WIDTH iterations
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  request present
- op_ready  out  1  block can accept; high only in IDLE
- op_code  in  4  operation select (map below)
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: result/flags/err updated
- result  out  2*WIDTH  last completed result (held until next done)
- flags  out  4  {zero, neg, carry, ovf} of last result
- err  out  1  last op was unsupported or divide-by-zero; held with result

## Operation
- Opcode map: 0000 add A+B; 0001 sub A-B; 0010 mul unsigned A*B (full 2*WIDTH); 0011 div unsigned, result = {remainder, quotient}; 01xx unsupported (float slot); 1000 and; 1001 or; 1010 nor; 1011 not A; 1100 L<<1; 1101 L>>1 logical; 1110 L>>>1 arithmetic; 1111 rotate right by 1; L = result[WIDTH-1:0].
- Handshake: accept when op_valid && op_ready at a rising edge; op_code/op_a/op_b latched then; inputs ignored until back in IDLE.
- States: IDLE -> EXEC (codes 0000,0001,01xx,1xxx) | MUL (0010) | DIV (0011); EXEC -> DONE; MUL/DIV -> DONE after WIDTH iterations; DONE -> IDLE.
- DIV with B==0 goes IDLE -> EXEC path: result=0, err=1, no iterations.
- 01xx: result=0, err=1. All other ops err=0.
- Logic/add/sub/shift results zero-extended to 2*WIDTH.
- flags: zero = (result==0) over full 2*WIDTH; neg = result[WIDTH-1] for single-cycle ops, result[2*WIDTH-1] for mul, 0 for div; carry/ovf from add/sub only (sub carry = no-borrow, i.e. A>=B unsigned), 0 otherwise.
- result, flags, err change only at the edge entering DONE.

## Timing
- Reset: state IDLE, op_ready=1, busy=0, done=0, result=0, flags=0, err=0; iteration counter and engine registers cleared. Reset mid-operation aborts with no done.
- Single-cycle op (and err paths): accept at edge k; result valid and done=1 for the cycle after edge k+1; op_ready=1 again after edge k+2.
- MUL/DIV: accept at edge k; iterations at edges k+1..k+WIDTH; done for the cycle after edge k+WIDTH+1; next accept at earliest edge k+WIDTH+2.
- done never asserts on two consecutive cycles; back-to-back throughput: one single-cycle op per 3 cycles.
- Shift ops read result as held at the accepting edge (result of the previous completed op).

## Configuration
- ALU_SEQ_DIV_EN defined: divider engine and DIV state compiled in, opcode 0011 as above.
- Not defined: no divider logic; opcode 0011 treated as unsupported (EXEC path, result=0, err=1, 1-cycle latency).

## Test plan
- Reset mid-MUL (A=5,B=7, rst at iteration 10) -> no done, op_ready=1, result=0, flags=0 after rst.
- add 0xFFFFFFFF+0x00000001 -> done 2 cycles after accept, result=0, flags={1,0,1,0}; sub 0x80000000-1 -> 0x7FFFFFFF, ovf=1, carry=1.
- mul 0xFFFFFFFF*0xFFFFFFFF -> done exactly 34 cycles after accept, result=0xFFFFFFFE00000001, neg=1.
- div 100/7 -> result={32'd2,32'd14}; div 5/0 -> err=1, result=0, done after 2 cycles (without ALU_SEQ_DIV_EN: 100/7 also err=1).
- Shift chain: add 0x80000001+0 then 1111 -> 0xC0000000; then 1110 -> 0xE0000000; then 1101 -> 0x70000000; then 1100 -> 0xE0000000.
- op_valid held high with changing op_code during MUL -> op_ready=0, no extra accept, latched op only; opcode 0101 -> err=1, result=0.
